// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: irq lines, control-unit strobes and status flags; master = control unit/peripherals, slave = interrupt_controller
interface interrupt_controller_if #(parameter int NUM_LINES = 8);
  logic [NUM_LINES-1:0] irq;
  logic io_store_retaddr;
  logic io_push_int_addr;
  logic io_push_retaddr;
  logic io_push_ints;
  logic io_interrupt;
  logic in_service;
  modport master (output irq, io_store_retaddr, io_push_int_addr, io_push_retaddr, io_push_ints, input io_interrupt, in_service);
  modport slave (input irq, io_store_retaddr, io_push_int_addr, io_push_retaddr, io_push_ints, output io_interrupt, in_service);
endinterface

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-latched prioritised IRQs with retaddr save/restore on d_bus and vector address on int_addr_bus; ports clk, rst, bus (interrupt_controller_if.slave), d_bus (inout), int_addr_bus (out); IRQ_SYNC_EN adds a two-flop irq synchronizer
module interrupt_controller #(
  parameter int NUM_LINES = 8,
  parameter logic [15:0] VECTOR_BASE = 16'hFFF0
) (
  input  logic clk,
  input  logic rst,
  interrupt_controller_if.slave bus,
  inout  logic [15:0] d_bus,
  output logic [15:0] int_addr_bus
);
  logic [NUM_LINES-1:0] s, prev, pending, rise, clr;
  logic [15:0] retaddr;
  logic [3:0] vec_idx, sel;
  logic addr_drive, in_svc, any, ack, d_drive;
`ifdef IRQ_SYNC_EN
  logic [NUM_LINES-1:0] sync1, sync2;
  always_ff @(posedge clk) begin
    sync1 <= rst ? '0 : bus.irq;
    sync2 <= rst ? '0 : sync1;
  end
  assign s = sync2;
`else
  assign s = bus.irq;
`endif
  always_comb begin
    sel = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--)
      if (pending[i]) sel = 4'(i);
  end
  assign any = |pending;
  assign ack = bus.io_store_retaddr && any;
  assign rise = s & ~prev;
  assign clr = ack ? (NUM_LINES'(1) << sel) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      pending <= '0;
      retaddr <= '0;
      vec_idx <= '0;
      addr_drive <= 1'b0;
      in_svc <= 1'b0;
    end else begin
      prev <= s;
      pending <= (pending & ~clr) | rise;
      retaddr <= bus.io_store_retaddr ? d_bus : retaddr;
      vec_idx <= ack ? sel : vec_idx;
      addr_drive <= bus.io_push_int_addr;
      in_svc <= ack ? 1'b1 : bus.io_push_retaddr ? 1'b0 : in_svc;
    end
  end
  assign bus.io_interrupt = any;
  assign bus.in_service = in_svc;
  assign d_drive = bus.io_push_retaddr || bus.io_push_ints;
  assign d_bus = d_drive ? (bus.io_push_retaddr ? retaddr : 16'(pending)) : 16'bz;
  assign int_addr_bus = addr_drive ? VECTOR_BASE + 16'(vec_idx) : 16'bz;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: randomized + directed scoreboard bench against a behavioural interrupt model
module tb_interrupt_controller;
  localparam int N = 8;
  localparam logic [15:0] VB = 16'hFFF0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  interrupt_controller_if #(.NUM_LINES(N)) bus ();
  wire [15:0] d_bus;
  wire [15:0] int_addr_bus;
  logic tb_en = 1'b0;
  logic [15:0] tb_val = '0;
  assign d_bus = tb_en ? tb_val : 16'bz;
  interrupt_controller #(.NUM_LINES(N), .VECTOR_BASE(VB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .d_bus(d_bus),
    .int_addr_bus(int_addr_bus)
  );
  typedef struct {
    logic intr, svc, d_care, d_z, a_z;
    logic [15:0] d, a;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [N-1:0] cur = '0;
  logic [N-1:0] m_pend, m_prev;
  logic [N-1:0] dly[$];
  logic [15:0] m_ret;
  int m_vec;
  bit m_svc, m_ad, m_valid = 0;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    logic dz, az;
    if (q.size() > 0) begin
      e = q.pop_front();
      dz = (d_bus === 16'hzzzz);
      az = (int_addr_bus === 16'hzzzz);
      chk("io_interrupt", 16'(bus.io_interrupt), 16'(e.intr));
      chk("in_service", 16'(bus.in_service), 16'(e.svc));
      chk("int_addr_bus_z", 16'(az), 16'(e.a_z));
      if (!e.a_z) chk("int_addr_bus", int_addr_bus, e.a);
      if (e.d_care) begin
        chk("d_bus_z", 16'(dz), 16'(e.d_z));
        if (!e.d_z) chk("d_bus", d_bus, e.d);
      end
    end
  end
  task automatic model_edge(input logic r, input logic st, input logic pia, input logic pra, input logic [15:0] dv);
    logic [N-1:0] s, np;
    int sel;
    if (r) begin
      m_pend = '0; m_prev = '0; m_ret = '0; m_vec = 0; m_svc = 0; m_ad = 0; m_valid = 1;
      dly.delete();
`ifdef IRQ_SYNC_EN
      dly.push_back('0);
      dly.push_back('0);
`endif
      return;
    end
`ifdef IRQ_SYNC_EN
    s = dly[0];
    void'(dly.pop_front());
    dly.push_back(cur);
`else
    s = cur;
`endif
    sel = -1;
    for (int i = 0; i < N; i++)
      if (m_pend[i]) begin sel = i; break; end
    np = m_pend;
    if (st) m_ret = dv;
    if (st && sel >= 0) begin
      np[sel] = 1'b0;
      m_vec = sel;
      m_svc = 1;
    end else if (pra) m_svc = 0;
    m_pend = np | (s & ~m_prev);
    m_prev = s;
    m_ad = pia;
  endtask
  task automatic step(input logic r, input logic st, input logic pia, input logic pra, input logic pi, input logic [15:0] dv);
    exp_t e;
    rst = r;
    bus.irq = cur;
    bus.io_store_retaddr = st;
    bus.io_push_int_addr = pia;
    bus.io_push_retaddr = pra;
    bus.io_push_ints = pi;
    tb_en = st && !pra && !pi;
    tb_val = dv;
    if (m_valid) begin
      e.intr = m_pend != 0;
      e.svc = m_svc;
      e.d_care = !tb_en;
      e.d_z = !(pra || pi);
      e.d = pra ? m_ret : 16'(m_pend);
      e.a_z = !m_ad;
      e.a = VB + 16'(m_vec);
      q.push_back(e);
    end
    @(posedge clk);
    model_edge(r, st, pia, pra, dv);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 16'h0);
  endtask
  initial begin
    bus.irq = '0;
    bus.io_store_retaddr = 0;
    bus.io_push_int_addr = 0;
    bus.io_push_retaddr = 0;
    bus.io_push_ints = 0;
    step(1, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    idle(2);
    step(0, 0, 0, 0, 1, 16'h0);
    cur = 8'h08;
    step(0, 0, 0, 0, 0, 16'h0);
    cur = '0;
    idle(4);
    step(0, 1, 1, 0, 0, 16'h0123);
    idle(2);
    step(0, 0, 0, 1, 0, 16'h0);
    idle(1);
    cur = 8'h22;
    step(0, 0, 0, 0, 0, 16'h0);
    cur = '0;
    idle(4);
    step(0, 0, 0, 0, 1, 16'h0);
    step(0, 1, 1, 0, 0, 16'h1111);
    idle(1);
    step(0, 1, 1, 0, 0, 16'h2222);
    idle(2);
    step(0, 0, 0, 1, 1, 16'h0);
    cur = 8'h04;
    step(0, 0, 0, 0, 0, 16'h0);
    cur = '0;
    idle(4);
    cur = 8'h04;
`ifdef IRQ_SYNC_EN
    idle(2);
`endif
    step(0, 1, 1, 0, 0, 16'h3333);
    idle(2);
    step(0, 1, 1, 0, 0, 16'h4444);
    cur = '0;
    idle(1);
    step(0, 0, 0, 1, 0, 16'h0);
    cur = 8'h01;
    idle(10);
    cur = '0;
    idle(3);
    step(0, 1, 1, 0, 0, 16'h5555);
    idle(2);
    step(0, 0, 0, 1, 0, 16'h0);
    cur = 8'h80;
    idle(4);
    step(0, 1, 1, 0, 0, 16'h6666);
    step(1, 0, 0, 0, 0, 16'h0);
    idle(3);
    for (int c = 0; c < 2000; c++) begin
      int k;
      cur = cur ^ N'($urandom & $urandom & $urandom);
      k = $urandom_range(0, 9);
      if ($urandom_range(0, 199) == 0) step(1, 0, 0, 0, 0, 16'h0);
      else if (k == 0) step(0, 1, $urandom_range(0, 3) != 0, 0, 0, 16'($urandom));
      else if (k == 1) step(0, 0, 0, 1, 0, 16'h0);
      else if (k == 2) step(0, 0, 0, 0, 1, 16'h0);
      else if (k == 3) step(0, 0, 0, 1, 1, 16'h0);
      else if (k == 4) step(0, 0, 1, 0, 0, 16'h0);
      else step(0, 0, 0, 0, 0, 16'h0);
    end
    idle(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 16'(q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
